// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: 5-bit opcode values
// (taken from IR[7:3]) and the 2-bit sequencer state encoding.
package inst_sequencer_pkg;

  localparam logic [4:0] OP_NOP          = 5'b00000;
  localparam logic [4:0] OP_MOV_REG_RC   = 5'b00001;
  localparam logic [4:0] OP_MOV_CONST_RC = 5'b00010;
  localparam logic [4:0] OP_MOV_RC_REG   = 5'b00011;
  localparam logic [4:0] OP_MOV_REG_RA   = 5'b00100;
  localparam logic [4:0] OP_LOAD         = 5'b00101;
  localparam logic [4:0] OP_STORE        = 5'b00110;
  localparam logic [4:0] OP_NOT          = 5'b00111;
  localparam logic [4:0] OP_AND          = 5'b01001;
  localparam logic [4:0] OP_OR           = 5'b01010;
  localparam logic [4:0] OP_XOR          = 5'b01011;
  localparam logic [4:0] OP_HLT          = 5'b11111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MEM   = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } seq_state_e;

  // Opcode field of an instruction byte.
  function automatic logic [4:0] opcode_of(input logic [7:0] ibyte);
    return ibyte[7:3];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: hold at all-ones once reached.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register; clear has priority.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/inst_sequencer.sv
// Fetch/execute sequencer: owns PC and IR, fetches over the imem handshake,
// sequences load/store over the dmem handshake, implements HLT and counts
// retired instructions. Optional macro SEQ_SINGLE_STEP_EN adds a debug
// single-step gate on instruction fetch.
// All handshake/control outputs are registered from the next state so that
// reset drives every one of them low on the following edge.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int PC_WIDTH  = 8,
  parameter int RET_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PC_WIDTH-1:0]  imemAddr,
  output logic                 imemReq,
  input  logic                 imemAck,
  input  logic [7:0]           imemRdata,
  output logic [7:0]           inst,
  output logic                 execStrobe,
  output logic                 dmemReq,
  output logic                 dmemWe,
  input  logic                 dmemAck,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                 dbgStepMode,
  input  logic                 dbgStep,
`endif
  output logic                 halted,
  output logic [RET_WIDTH-1:0] retired
);

  seq_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic                imem_req_q, imem_req_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic                exec_q, exec_d;
  logic                halted_q, halted_d;
  logic [7:0]          inst_q, inst_d;
  logic                fetch_ack;
  logic                fetch_go;

  // An ack only counts while our request is actually on the bus.
  assign fetch_ack = (state_q == FETCH) && imem_req_q && imemAck;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_pend_q, step_pend_d;

  // One pending step at most; consumed by the fetch ack it enabled.
  always_comb begin
    step_pend_d = (step_pend_q && !fetch_ack) || dbgStep;
    fetch_go    = !dbgStepMode || step_pend_d;
  end

  // Pending-step latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_pend_q <= 1'b0;
    end else begin
      step_pend_q <= step_pend_d;
    end
  end
`else
  assign fetch_go = 1'b1;
`endif

  // Next-state, PC/IR update and next registered outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH: begin
        if (fetch_ack) begin
          ir_d = imemRdata;
          pc_d = pc_q + PC_WIDTH'(1);
          case (opcode_of(imemRdata))
            OP_HLT:            state_d = HALT;
            OP_LOAD, OP_STORE: state_d = MEM;
            default:           state_d = EXEC;
          endcase
        end
      end
      MEM: begin
        if (dmemAck) begin
          state_d = EXEC;
        end
      end
      EXEC:    state_d = FETCH;
      default: state_d = HALT;
    endcase

    // Once raised, a fetch request is held until its ack.
    imem_req_d = (state_d == FETCH) &&
                 (fetch_go || ((state_q == FETCH) && imem_req_q));
    dmem_req_d = (state_d == MEM);
    dmem_we_d  = (state_d == MEM) && (opcode_of(ir_d) == OP_STORE);
    exec_d     = (state_d == EXEC);
    halted_d   = (state_d == HALT);
    // Control unit sees NOP unless an instruction is in flight.
    inst_d     = ((state_d == MEM) || (state_d == EXEC)) ? ir_d : 8'h00;
  end

  // State, PC, IR and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      exec_q     <= 1'b0;
      halted_q   <= 1'b0;
      inst_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      exec_q     <= exec_d;
      halted_q   <= halted_d;
      inst_q     <= inst_d;
    end
  end

  sat_counter #(
    .WIDTH (RET_WIDTH)
  ) u_retired (
    .clk   (clk),
    .clr   (rst),
    .inc   (state_q == EXEC),
    .count (retired)
  );

  assign imemAddr   = pc_q;
  assign imemReq    = imem_req_q;
  assign dmemReq    = dmem_req_q;
  assign dmemWe     = dmem_we_q;
  assign execStrobe = exec_q;
  assign halted     = halted_q;
  assign inst       = inst_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer. A second instance with RET_WIDTH=2
// shares all inputs to observe retired-counter saturation.
module tb_inst_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemAck, dmemAck;
  logic [7:0]  imemRdata;

  logic [7:0]  imemAddr, inst;
  logic        imemReq, execStrobe, dmemReq, dmemWe, halted;
  logic [15:0] retired;

  logic [7:0]  imemAddr_2, inst_2;
  logic        imemReq_2, execStrobe_2, dmemReq_2, dmemWe_2, halted_2;
  logic [1:0]  retired_2;

`ifdef SEQ_SINGLE_STEP_EN
  logic dbgStepMode, dbgStep;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  inst_sequencer #(.PC_WIDTH(8), .RET_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .imemAddr(imemAddr), .imemReq(imemReq), .imemAck(imemAck), .imemRdata(imemRdata),
    .inst(inst), .execStrobe(execStrobe),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAck(dmemAck),
`ifdef SEQ_SINGLE_STEP_EN
    .dbgStepMode(dbgStepMode), .dbgStep(dbgStep),
`endif
    .halted(halted), .retired(retired)
  );

  inst_sequencer #(.PC_WIDTH(8), .RET_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .imemAddr(imemAddr_2), .imemReq(imemReq_2), .imemAck(imemAck), .imemRdata(imemRdata),
    .inst(inst_2), .execStrobe(execStrobe_2),
    .dmemReq(dmemReq_2), .dmemWe(dmemWe_2), .dmemAck(dmemAck),
`ifdef SEQ_SINGLE_STEP_EN
    .dbgStepMode(dbgStepMode), .dbgStep(dbgStep),
`endif
    .halted(halted_2), .retired(retired_2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // flags = {imemReq, dmemReq, dmemWe, execStrobe, halted}
  task automatic check_outs(input string tag, input logic [4:0] flags, input logic [7:0] iexp);
    check(tag, {19'd0, imemReq, dmemReq, dmemWe, execStrobe, halted, inst}, {19'd0, flags, iexp});
    check({tag, "_w2"}, {19'd0, imemReq_2, dmemReq_2, dmemWe_2, execStrobe_2, halted_2, inst_2},
          {19'd0, flags, iexp});
  endtask

  // Wait (bounded) for a fetch request, check its address, ack with one byte.
  task automatic fetch(input logic [7:0] b, input logic [7:0] addr, input string tag,
                       output int waits);
    waits = 0;
    while (imemReq !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check({tag, "_req"}, {31'd0, imemReq}, 32'd1);
    check({tag, "_addr"}, {24'd0, imemAddr}, {24'd0, addr});
    check({tag, "_addr_w2"}, {24'd0, imemAddr_2}, {24'd0, addr});
    $display("fetch %s addr=%0d byte=0x%02h waits=%0d", tag, imemAddr, b, waits);
    imemRdata = b;
    imemAck   = 1'b1;
    @(negedge clk);
    imemAck   = 1'b0;
    imemRdata = 8'h00;
  endtask

  initial begin
    int w;
    int wsum;
    int strobes;
    int bad;

    rst = 1'b1; imemAck = 1'b0; dmemAck = 1'b0; imemRdata = 8'h00;
`ifdef SEQ_SINGLE_STEP_EN
    dbgStepMode = 1'b0; dbgStep = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_outs("reset_outs", 5'b00000, 8'h00);
    check("reset_pc", {24'd0, imemAddr}, 32'd0);
    check("reset_retired", {16'd0, retired}, 32'd0);

    // Release reset; a stray ack arrives before the request is raised.
    rst = 1'b0; imemAck = 1'b1; imemRdata = 8'hF8;
    @(negedge clk);
    imemAck = 1'b0; imemRdata = 8'h00;

    // AND r0: zero-wait, 2-cycle instruction.
    fetch(8'h48, 8'd0, "and", w);
    check("and_wait", w, 0);
    check_outs("and_exec", 5'b00010, 8'h48);
    check("and_pc", {24'd0, imemAddr}, 32'd1);
    check("and_ret_before", {16'd0, retired}, 32'd0);
    @(negedge clk);
    check("and_ret_after", {16'd0, retired}, 32'd1);

    // Load r2 with dmemAck on the 4th MEM cycle.
    fetch(8'h2A, 8'd1, "load", w);
    for (int i = 0; i < 4; i++) begin
      check_outs($sformatf("load_mem%0d", i), 5'b01000, 8'h2A);
      if (i == 3) dmemAck = 1'b1;
      @(negedge clk);
    end
    dmemAck = 1'b0;
    check_outs("load_exec", 5'b00010, 8'h2A);
    @(negedge clk);
    check("load_ret", {16'd0, retired}, 32'd2);

    // Store with zero-wait data memory.
    fetch(8'h31, 8'd2, "store", w);
    check("store_wait", w, 0);
    check_outs("store_mem", 5'b01100, 8'h31);
    dmemAck = 1'b1;
    @(negedge clk);
    dmemAck = 1'b0;
    check_outs("store_exec", 5'b00010, 8'h31);
    @(negedge clk);
    check("store_ret", {16'd0, retired}, 32'd3);
    check("store_ret_w2", {30'd0, retired_2}, 32'd3);

    // NOPs from PC 3 through 255; the PC then wraps to 0.
    wsum = 0; strobes = 0;
    for (int a = 3; a <= 255; a++) begin
      fetch(8'h00, a[7:0], "nop", w);
      wsum += w;
      if (execStrobe === 1'b1) strobes++;
      @(negedge clk);
    end
    check("nop_waits", wsum, 0);
    check("nop_strobes", strobes, 253);
    check("wrap_addr", {24'd0, imemAddr}, 32'd0);
    check("wrap_req", {31'd0, imemReq}, 32'd1);
    check("nop_retired", {16'd0, retired}, 32'd256);
    check("sat_retired_w2", {30'd0, retired_2}, 32'd3);

    // HLT at PC 0.
    fetch(8'hF8, 8'd0, "hlt", w);
    check_outs("halt_outs", 5'b00001, 8'h00);
    check("halt_pc", {24'd0, imemAddr}, 32'd1);
    imemAck = 1'b1; imemRdata = 8'h48;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (imemReq !== 1'b0 || execStrobe !== 1'b0 || halted !== 1'b1 ||
          dmemReq !== 1'b0 || imemAddr !== 8'd1) bad++;
    end
    imemAck = 1'b0; imemRdata = 8'h00;
    check("halt_stuck", bad, 0);
    check("halt_retired", {16'd0, retired}, 32'd256);

    // Reset in the middle of a store with dmemAck in the same cycle.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fetch(8'h31, 8'd0, "rst_store", w);
    check_outs("rst_store_mem", 5'b01100, 8'h31);
    rst = 1'b1; dmemAck = 1'b1;
    @(negedge clk);
    check_outs("rst_mid_outs", 5'b00000, 8'h00);
    check("rst_mid_pc", {24'd0, imemAddr}, 32'd0);
    check("rst_mid_retired", {16'd0, retired}, 32'd0);
    rst = 1'b0; dmemAck = 1'b0;
    @(negedge clk);
    check_outs("post_rst_fetch", 5'b10000, 8'h00);
    fetch(8'h48, 8'd0, "post_rst_and", w);
    check_outs("post_rst_exec", 5'b00010, 8'h48);
    @(negedge clk);
    check("post_rst_retired", {16'd0, retired}, 32'd1);

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step: no fetch until a step pulse; one pulse, one instruction.
    rst = 1'b1; dbgStepMode = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (imemReq !== 1'b0) bad++;
    end
    check("step_idle", bad, 0);
    dbgStep = 1'b1;
    @(negedge clk);
    dbgStep = 1'b0;
    check("step_req", {31'd0, imemReq}, 32'd1);
    fetch(8'h48, 8'd0, "step_and", w);
    check("step_wait", w, 0);
    check_outs("step_exec", 5'b00010, 8'h48);
    // A pulse during EXEC is held for the next FETCH.
    dbgStep = 1'b1;
    @(negedge clk);
    dbgStep = 1'b0;
    fetch(8'h00, 8'd1, "step_nop", w);
    check_outs("step_nop_exec", 5'b00010, 8'h00);
    bad = 0; strobes = 0;
    repeat (6) begin
      @(negedge clk);
      if (imemReq !== 1'b0) bad++;
      if (execStrobe === 1'b1) strobes++;
    end
    check("step_no_more_req", bad, 0);
    check("step_no_more_exec", strobes, 0);
    check("step_retired", {16'd0, retired}, 32'd2);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
